// File: rtl/en_extmem_bridge_pkg.sv
// Shared types for the ElectronNest external-memory bridge: token structs,
// bus widths and the bridge FSM state enum (package pkg_en).
package pkg_en;

    localparam int WIDTH_DATA   = 32;
    localparam int WIDTH_EXADDR = 16;
    localparam int WIDTH_INDEX  = WIDTH_EXADDR;

    // Forward token: valid, route/config/crossbar flags, index, data
    typedef struct packed {
        logic                   v;
        logic                   a;
        logic                   r;
        logic                   c;
        logic [WIDTH_INDEX-1:0] i;
        logic [WIDTH_DATA-1:0]  d;
    } FTk_t;

    // Backward token: n is the stall (not-ready) indication
    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAD  = 2'd1,
        IMG  = 2'd2,
        RUN  = 2'd3
    } extmem_st_t;

endpackage

// File: rtl/en_extmem_bridge_ld_pipe.sv
// extmem_ld_pipe: LAT-deep valid/data shift register. A high stall_i freezes
// every stage so the tail token stays stable until the consumer takes it.
module extmem_ld_pipe #(
    parameter int LAT = 1,
    parameter int W   = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         stall_i,
    input  logic         vld_i,
    input  logic [W-1:0] dat_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o
);

    logic [LAT:1]        vld_q;
    logic [LAT:1][W-1:0] dat_q;

    // Shift valid/data one stage per unstalled cycle; empty slots carry zero data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            dat_q <= '0;
        end else if (!stall_i) begin
            vld_q[1] <= vld_i;
            dat_q[1] <= vld_i ? dat_i : '0;
            for (int k = 2; k <= LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                dat_q[k] <= dat_q[k-1];
            end
        end
    end

    assign vld_o = vld_q[LAT];
    assign dat_o = dat_q[LAT];

endmodule

// File: rtl/en_extmem_bridge.sv
// en_extmem_bridge: external-memory port for the ElectronNest array.
// Streams a padded boot image into the Ld port, then serves loads with LD_LAT
// latency (legal 1..4) and commits stores into an on-chip RAM of DEPTH words.
// Build option EXTMEM_INDEX_EN: load tokens carry their address in .i.
module en_extmem_bridge
    import pkg_en::*;
#(
    parameter int DEPTH    = 1024,
    parameter int NUM_BOOT = 5,
    parameter int BOOT_PAD = 3,
    parameter int LD_LAT   = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    I_Boot,
    input  logic                    I_Init_We,
    input  logic [WIDTH_EXADDR-1:0] I_Init_Adr,
    input  logic [WIDTH_DATA-1:0]   I_Init_Dat,
    input  logic                    I_Ld_Req,
    input  logic [WIDTH_EXADDR-1:0] I_Ld_Addr,
    output FTk_t                    O_Ld_FTk,
    input  BTk_t                    I_Ld_BTk,
    output logic                    O_Ld_Busy,
    input  logic                    I_St_Req,
    input  logic [WIDTH_EXADDR-1:0] I_St_Addr,
    input  FTk_t                    I_St_FTk,
    output BTk_t                    O_St_BTk,
    output logic                    O_Err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = WIDTH_INDEX + WIDTH_DATA;
    localparam logic [WIDTH_EXADDR:0] DEPTH_W  = (WIDTH_EXADDR+1)'(DEPTH);
    localparam logic [15:0]           PAD_LAST = 16'(BOOT_PAD - 1);
    localparam logic [15:0]           IMG_LAST = 16'(NUM_BOOT - 1);

    extmem_st_t             state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [WIDTH_DATA-1:0]  mem_q [DEPTH];

    logic                   in_boot, busy_raw, ld_acc;
    logic                   ld_in_rng, st_in_rng, init_in_rng;
    logic                   st_fire, st_ok, init_ok, we;
    logic [AW-1:0]          ra, wa;
    logic [WIDTH_DATA-1:0]  wd, ram_rd, ld_rd;
    logic [WIDTH_INDEX-1:0] ld_idx;
    logic                   pipe_v;
    logic [PW-1:0]          pipe_dat;
    logic                   unused_ok;

    assign unused_ok = ^{I_Ld_BTk.t, I_Ld_BTk.v, I_Ld_BTk.c,
                         I_St_FTk.a, I_St_FTk.r, I_St_FTk.c, I_St_FTk.i};

    assign in_boot  = (state_q == PAD) || (state_q == IMG);
    assign busy_raw = (state_q != RUN) || I_Ld_BTk.n;
    assign ld_acc   = I_Ld_Req && !busy_raw;

    // Busy is forced low while reset is held so every output reads 0 in reset
    assign O_Ld_Busy = busy_raw && !reset;

    assign ld_in_rng   = {1'b0, I_Ld_Addr}  < DEPTH_W;
    assign st_in_rng   = {1'b0, I_St_Addr}  < DEPTH_W;
    assign init_in_rng = {1'b0, I_Init_Adr} < DEPTH_W;

    // Stores are refused only while the boot image is streaming
    assign st_fire = I_St_Req && I_St_FTk.v && !in_boot;
    assign st_ok   = st_fire && st_in_rng;
    assign init_ok = I_Init_We && (state_q == IDLE) && init_in_rng;

    // Single write port: a live store wins over preload in the same cycle
    assign we = st_ok || init_ok;
    assign wa = st_ok ? I_St_Addr[AW-1:0] : I_Init_Adr[AW-1:0];
    assign wd = st_ok ? I_St_FTk.d        : I_Init_Dat;

    // Single read port shared by the boot image walk and RUN loads
    assign ra     = (state_q == IMG) ? cnt_q[AW-1:0] : I_Ld_Addr[AW-1:0];
    assign ram_rd = mem_q[ra];

    // Write-first: a same-cycle store to the load address forwards its data
    assign ld_rd = !ld_in_rng                         ? '0 :
                   (st_ok && (I_St_Addr == I_Ld_Addr)) ? I_St_FTk.d : ram_rd;

`ifdef EXTMEM_INDEX_EN
    assign ld_idx = I_Ld_Addr;
`else
    assign ld_idx = '0;
`endif

    // Backing RAM: no reset so contents survive a mid-boot or mid-load reset
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[wa] <= wd;
        end
    end

    extmem_ld_pipe #(
        .LAT (LD_LAT),
        .W   (PW)
    ) u_ld_pipe (
        .clk_i   (clock),
        .rst_i   (reset),
        .stall_i (I_Ld_BTk.n),
        .vld_i   (ld_acc),
        .dat_i   ({ld_idx, ld_rd}),
        .vld_o   (pipe_v),
        .dat_o   (pipe_dat)
    );

    // State, boot counter and sticky error registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next state and token outputs; boot words hold while the array stalls
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        O_Ld_FTk = '0;
        O_St_BTk = '0;
        O_St_BTk.n = in_boot;
        err_d    = err_q || (ld_acc && !ld_in_rng) || (st_fire && !st_in_rng);
        case (state_q)
            IDLE: begin
                if (I_Boot) begin
                    cnt_d   = '0;
                    state_d = (BOOT_PAD > 0) ? PAD : ((NUM_BOOT > 0) ? IMG : RUN);
                end
            end
            PAD: begin
                O_Ld_FTk.v = 1'b1;
                O_Ld_FTk.a = (cnt_q == '0);
                if (!I_Ld_BTk.n) begin
                    if (cnt_q == PAD_LAST) begin
                        cnt_d   = '0;
                        state_d = (NUM_BOOT > 0) ? IMG : RUN;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            IMG: begin
                O_Ld_FTk.v = 1'b1;
                O_Ld_FTk.a = (BOOT_PAD == 0) && (cnt_q == '0);
                O_Ld_FTk.d = ram_rd;
                if (!I_Ld_BTk.n) begin
                    if (cnt_q == IMG_LAST) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            RUN: begin
                O_Ld_FTk.v = pipe_v;
                {O_Ld_FTk.i, O_Ld_FTk.d} = pipe_dat;
            end
            default: state_d = IDLE;
        endcase
    end

    assign O_Err = err_q;

endmodule
